// File: rtl/dsm_read_ctrl.sv
// Read sequencer/decimator for the flash bit-line delta-sigma modulator:
// settle, N conversion windows, average the captured counts, classify into a cell state.
//
// state   | meaning
// IDLE    | waiting for start, modulator off
// SETTLE  | trim applied, dsm_en low while vref settles
// CONVERT | dsm_en high for the conversion window
// CAPTURE | dsm_en still high, count sampled on the falling edge
// GAP     | dsm_en low to clear the modulator count
// DONE    | result/cell_state valid, done pulse
module dsm_read_ctrl #(
    parameter int SETTLE_CYC = 4,
    parameter int WIN_CYC    = 256,
    parameter int AVG_SHIFT  = 2,
    parameter int TH0        = 64,
    parameter int TH1        = 192,
    parameter int TH2        = 320
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] trim_in,
    input  logic [8:0] dsm_count,
    output logic       dsm_en,
    output logic [7:0] dsm_chrg_trim,
    output logic       busy,
    output logic       done,
    output logic [8:0] result,
    output logic [1:0] cell_state,
    output logic       sat
);

    localparam int N_CONV = 1 << AVG_SHIFT;
    localparam int ACC_W  = 9 + AVG_SHIFT;

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_CONVERT, S_CAPTURE, S_GAP, S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [8:0]         tmr;
    logic [3:0]         conv_cnt;
    logic [ACC_W-1:0]   acc;
    logic [8:0]         samp;
    logic               samp_bad;
    logic [8:0]         avg;
    logic [1:0]         avg_class;
    logic               tmr_zero;
    logic               more_conv;

    assign tmr_zero  = (tmr == 9'd0);
    assign more_conv = (conv_cnt < 4'(N_CONV));
    assign avg       = 9'(acc >> AVG_SHIFT);

    always_comb begin
        avg_class = 2'd3;
        if (int'(avg) < TH0)      avg_class = 2'd0;
        else if (int'(avg) < TH1) avg_class = 2'd1;
        else if (int'(avg) < TH2) avg_class = 2'd2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_SETTLE;
            S_SETTLE:  if (tmr_zero) state_nxt = S_CONVERT;
            S_CONVERT: if (tmr_zero) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_GAP;
            S_GAP:     state_nxt = more_conv ? S_CONVERT : S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dsm_en = (state == S_CONVERT) || (state == S_CAPTURE);
        busy   = (state != S_IDLE) && (state != S_DONE);
        done   = (state == S_DONE);
    end

    // Sampling on the falling edge keeps the capture clear of the modulator's rising-edge update.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            samp     <= '0;
            samp_bad <= 1'b0;
        end else if (state == S_CAPTURE) begin
            if ($isunknown(dsm_count)) begin
                samp     <= '0;
                samp_bad <= 1'b1;
            end else begin
                samp     <= dsm_count;
                samp_bad <= (int'(dsm_count) >= WIN_CYC);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr           <= '0;
            conv_cnt      <= '0;
            acc           <= '0;
            dsm_chrg_trim <= '0;
            result        <= '0;
            cell_state    <= '0;
            sat           <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    dsm_chrg_trim <= trim_in;
                    acc           <= '0;
                    sat           <= 1'b0;
                    conv_cnt      <= '0;
                    tmr           <= 9'(SETTLE_CYC - 1);
                end
                S_SETTLE: tmr <= tmr_zero ? 9'(WIN_CYC - 1) : tmr - 9'd1;
                S_CONVERT: if (!tmr_zero) tmr <= tmr - 9'd1;
                S_CAPTURE: begin
                    acc      <= acc + ACC_W'(samp);
                    conv_cnt <= conv_cnt + 4'd1;
                    if (samp_bad) sat <= 1'b1;
                end
                S_GAP: begin
                    if (more_conv) begin
                        tmr <= 9'(WIN_CYC - 1);
                    end else begin
                        result     <= avg;
                        cell_state <= avg_class;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
